cpu_run_ctrl: RTL

- Run-control and supervision block that drives the CPU from the other side of the clk/reset interface.
- It holds the single-cycle MIPS core in reset for a programmable number of cycles, then releases it.
- While the core runs, it watches the fetch PC and counts cycles.
- On halt (PC stuck), fault (illegal PC) or timeout it terminates the run: it freezes the core with cpu_reset and reports a sticky status, so benches and top levels stop on a decided condition.

---
 rtl/cpu_run_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the core in reset, releases it, then supervises
// the fetch PC and ends the run on halt, fault or timeout.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter logic [31:0] PC_RESET     = 32'h0000_3000,
    parameter logic [31:0] IM_BASE      = 32'h0000_3000,
    parameter int unsigned IM_BYTES     = 4096,
    parameter int unsigned STALL_LIMIT  = 3,
    parameter int unsigned MAX_CYCLES   = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        cpu_reset,
    output logic        running,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] cycle_count,
    output logic [31:0] last_pc
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_HALT,
        S_TIMEOUT,
        S_FAULT
    } state_t;

    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_BYTES);

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] same_cnt;
    logic [31:0] prev_pc;
    logic        first;

    logic [31:0] same_nxt;
    logic        fault;
    logic        halt;
    logic        tmo;

    always_comb begin
        same_nxt = (pc == prev_pc) ? same_cnt + 32'd1 : 32'd0;
        fault    = (first && (pc != PC_RESET))
                 || (pc[1:0] != 2'b00)
                 || (pc < IM_BASE)
                 || ({1'b0, pc} >= IM_END);
        halt     = (same_nxt >= STALL_LIMIT);
        tmo      = (cycle_count == MAX_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HOLD;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= 2'b00;
            cycle_count <= '0;
            last_pc     <= '0;
            hold_cnt    <= '0;
            same_cnt    <= '0;
            prev_pc     <= '0;
            first       <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    hold_cnt  <= hold_cnt + 32'd1;
                    first     <= 1'b1;
                    if (hold_cnt == RESET_CYCLES - 1) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    prev_pc     <= pc;
                    same_cnt    <= same_nxt;
                    first       <= 1'b0;
                    // fault outranks halt, halt outranks timeout
                    if (fault || halt || tmo) begin
                        last_pc   <= pc;
                        done      <= 1'b1;
                        running   <= 1'b0;
                        cpu_reset <= 1'b1;
                        if (fault) begin
                            state  <= S_FAULT;
                            status <= 2'b11;
                        end else if (halt) begin
                            state  <= S_HALT;
                            status <= 2'b01;
                        end else begin
                            state  <= S_TIMEOUT;
                            status <= 2'b10;
                        end
                    end
                end
                S_HALT, S_TIMEOUT, S_FAULT: begin
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state     <= S_HOLD;
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    done      <= 1'b0;
                    status    <= 2'b00;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
